// File: rtl/button_press_gen.sv
// Button waveform generator: timed press/release sequences on pause/toggle.
// Ports: clk, reset (sync, active-high); cmd_valid/cmd_ready handshake with
// cmd_sel (0 pause, 1 toggle), cmd_hold, cmd_repeat; pause_out/toggle_out
// button levels; busy; done pulse; press_count releases issued (wraps).
// Optional: define BUTTON_BOUNCE_EN for a 1,0,1,0 bounce lead-in per press.
module button_press_gen #(
    parameter int HOLD_W     = 16,
    parameter int GAP_CYCLES = 4,
    parameter int REP_W      = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_sel,
    input  logic [HOLD_W-1:0] cmd_hold,
    input  logic [REP_W-1:0]  cmd_repeat,
    output logic              pause_out,
    output logic              toggle_out,
    output logic              busy,
    output logic              done,
    output logic [7:0]        press_count
);

    // One down-counter serves hold, gap and bounce phases.
    localparam int GAP_W = (GAP_CYCLES > 4) ? $clog2(GAP_CYCLES) : 2;
    localparam int CNT_W = (HOLD_W > GAP_W) ? HOLD_W : GAP_W;

`ifdef BUTTON_BOUNCE_EN
    typedef enum logic [1:0] {IDLE, HOLD, GAP, BOUNCE} state_t;
`else
    typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;
`endif

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [REP_W-1:0]   rep_q, rep_n;
    logic [HOLD_W-1:0]  hold_q, hold_n, ld_hold;
    logic               sel_q, sel_n;
    logic               lvl_n;
    logic               done_n;
    logic               inc;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        rep_n   = rep_q;
        hold_n  = hold_q;
        sel_n   = sel_q;
        lvl_n   = 1'b0;
        done_n  = 1'b0;
        inc     = 1'b0;
        ld_hold = (cmd_hold == '0) ? HOLD_W'(1) : cmd_hold;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    sel_n  = cmd_sel;
                    hold_n = ld_hold;
                    // rep counts presses remaining after the current one
                    rep_n  = (cmd_repeat == '0) ? '0 : cmd_repeat - 1'b1;
                    lvl_n  = 1'b1;
`ifdef BUTTON_BOUNCE_EN
                    state_n = BOUNCE;
                    cnt_n   = CNT_W'(3);
`else
                    state_n = HOLD;
                    cnt_n   = CNT_W'(ld_hold - 1'b1);
`endif
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    state_n = GAP;
                    cnt_n   = CNT_W'(GAP_CYCLES - 1);
                    inc     = 1'b1;
                end else begin
                    cnt_n = cnt - 1'b1;
                    lvl_n = 1'b1;
                end
            end
            GAP: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else if (rep_q != '0) begin
                    rep_n = rep_q - 1'b1;
                    lvl_n = 1'b1;
`ifdef BUTTON_BOUNCE_EN
                    state_n = BOUNCE;
                    cnt_n   = CNT_W'(3);
`else
                    state_n = HOLD;
                    cnt_n   = CNT_W'(hold_q - 1'b1);
`endif
                end else begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
`ifdef BUTTON_BOUNCE_EN
            BOUNCE: begin
                // counter 3,2,1,0 maps to level 1,0,1,0 via its LSB
                if (cnt == '0) begin
                    state_n = HOLD;
                    cnt_n   = CNT_W'(hold_q - 1'b1);
                    lvl_n   = 1'b1;
                end else begin
                    cnt_n = cnt - 1'b1;
                    lvl_n = cnt_n[0];
                end
            end
`endif
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            rep_q       <= '0;
            hold_q      <= '0;
            sel_q       <= 1'b0;
            pause_out   <= 1'b0;
            toggle_out  <= 1'b0;
            done        <= 1'b0;
            press_count <= 8'd0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            rep_q       <= rep_n;
            hold_q      <= hold_n;
            sel_q       <= sel_n;
            pause_out   <= lvl_n & ~sel_n;
            toggle_out  <= lvl_n & sel_n;
            done        <= done_n;
            press_count <= press_count + {7'd0, inc};
        end
    end

endmodule

// File: tb/tb_button_press_gen.sv
// Bench for button_press_gen: directed and random commands checked against
// a per-cycle waveform model derived from accept time, hold, repeat, gap.
module tb_button_press_gen;

    localparam int HW = 16;
    localparam int G  = 4;
    localparam int RW = 4;
`ifdef BUTTON_BOUNCE_EN
    localparam int B = 4;
`else
    localparam int B = 0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_sel = 1'b0;
    logic [HW-1:0] cmd_hold = '0;
    logic [RW-1:0] cmd_repeat = '0;
    logic          cmd_ready;
    logic          pause_out;
    logic          toggle_out;
    logic          busy;
    logic          done;
    logic [7:0]    press_count;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    button_press_gen #(
        .HOLD_W(HW),
        .GAP_CYCLES(G),
        .REP_W(RW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_sel(cmd_sel),
        .cmd_hold(cmd_hold),
        .cmd_repeat(cmd_repeat),
        .pause_out(pause_out),
        .toggle_out(toggle_out),
        .busy(busy),
        .done(done),
        .press_count(press_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Called at a negedge while idle; returns at the negedge of the done cycle.
    task automatic run_cmd(input logic sel, input int hold, input int rep,
                           input bit keep);
        int h, r, p, n, off, lvl, rel;
        h = (hold == 0) ? 1 : hold;
        r = (rep == 0) ? 1 : rep;
        p = B + h + G;
        n = r * p + 1;
        chk("ready_before", cmd_ready, 1);
        cmd_valid  = 1'b1;
        cmd_sel    = sel;
        cmd_hold   = HW'(hold);
        cmd_repeat = RW'(rep);
        @(posedge clk);
        #1;
        cmd_valid  = keep;
        cmd_sel    = ~sel;
        cmd_hold   = HW'($urandom);
        cmd_repeat = RW'($urandom);
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            lvl = 0;
            if (c < n) begin
                off = (c - 1) % p;
                if (off < B) lvl = ((off % 2) == 0) ? 1 : 0;
                else         lvl = (off < B + h) ? 1 : 0;
            end
            rel = (c - 1 >= B + h) ? ((c - 1 - (B + h)) / p + 1) : 0;
            if (rel > r) rel = r;
            chk("pause", pause_out, sel ? 0 : lvl);
            chk("toggle", toggle_out, sel ? lvl : 0);
            chk("done", done, (c == n) ? 1 : 0);
            chk("busy", busy, (c < n) ? 1 : 0);
            chk("ready", cmd_ready, (c == n) ? 1 : 0);
            chk("count", press_count, (exp_cnt + rel) % 256);
            if (c < n) @(posedge clk);
        end
        exp_cnt = (exp_cnt + r) % 256;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pause", pause_out, 0);
        chk("rst_toggle", toggle_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_count", press_count, 0);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_ready", cmd_ready, 1);
        chk("post_rst_count", press_count, 0);

        run_cmd(1'b0, 3, 1, 1'b0);
        run_cmd(1'b1, 2, 3, 1'b0);
        run_cmd(1'b0, 0, 0, 1'b0);
        run_cmd(1'b1, 4, 2, 1'b1);
        run_cmd(1'b0, 1, 1, 1'b0);

        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("idle_busy", busy, 0);
            chk("idle_pause", pause_out, 0);
            chk("idle_done", done, 0);
        end

        cmd_valid  = 1'b1;
        cmd_sel    = 1'b0;
        cmd_hold   = HW'(10);
        cmd_repeat = RW'(1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("mid_c1", pause_out, 1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("mid_c2", pause_out, (B > 0) ? 0 : 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mid_pause", pause_out, 0);
            chk("mid_done", done, 0);
            chk("mid_busy", busy, 0);
            chk("mid_ready", cmd_ready, 1);
            chk("mid_count", press_count, 0);
            @(posedge clk);
        end
        @(negedge clk);

        for (int i = 0; i < 20; i++) begin
            run_cmd(1'($urandom_range(0, 1)), int'($urandom_range(0, 6)),
                    int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
        end

        for (int i = 0; i < 17; i++) begin
            run_cmd(1'b1, 0, 15, 1'b0);
        end

        @(posedge clk);
        @(negedge clk);
        chk("end_busy", busy, 0);
        chk("end_count", press_count, exp_cnt);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
